link_resp_buf: RTL
==================

# link_resp_buf

Responder end of the 4-phase req/ack byte link: accepts bytes offered by the link initiator (`req`/`data`), returns `ack`, and buffers accepted bytes in a small FIFO drained by a valid/ready consumer. It counts accepted bytes, holds the most recent byte, and asserts `done` once a packet of `PKT_LEN` bytes has been fully handshaken. It sits inside `link_top`-class designs as the receiving partner of the byte initiator.

## Interface
- `DEPTH`, 4: FIFO entries; power of 2, ≥2.
- `PKT_LEN`, 4: bytes per packet; ≥1, ≤255.
- `clk` input 1: single clock, all logic on rising edge.
- `rst` input 1: asynchronous, active-low reset (asserted when 0).
- `req` input 1: initiator request, same clock domain.
- `data` input 8: byte offered; valid whenever `req`=1.
- `ack` output 1: responder acknowledge.
- `out_valid` output 1: FIFO non-empty.
- `out_data` output 8: FIFO head byte.
- `out_ready` input 1: consumer pops head when `out_valid`&&`out_ready`.
- `clr` input 1: synchronous packet restart.
- `last_byte` output 8: most recently accepted byte.
- `byte_count` output 8: bytes accepted in current packet.
- `done` output 1: packet complete (level).
- `err` output 1: sticky protocol error.

## Operation
- States: REL (ack=0, wait `req`=0), IDLE (ack=0, arm), ACK_HI (ack=1, wait `req`=0), DONE (ack=0, packet complete).
- Reset state REL. All outputs 0 during/after reset; FIFO empty; `out_data`=0 while empty.
- REL -> IDLE when `req`=0.
- IDLE, `req`=1 and FIFO not full: push `data`, `last_byte`<=`data`, `byte_count`+1, -> ACK_HI.
- IDLE, `req`=1 and FIFO full: stay, `ack` stays 0 (backpressure; initiator holds `req`/`data`).
- ACK_HI, `req`=0: -> DONE if `byte_count`==`PKT_LEN`, else IDLE.
- DONE: `done`=1; `req`=1 sets `err` (no capture). Leaves only via `clr` or reset.
- `clr` (any state, highest priority after reset): `byte_count`, `done`, `err` <= 0, FIFO flushed, `last_byte` retained; next state REL if `req`=1 else IDLE.
- FIFO full test uses registered occupancy only: push blocked when full even if a pop occurs same cycle. Push+pop same cycle when non-full/non-empty: occupancy unchanged, order preserved.
- Pop independent of handshake state; continues in DONE.

## Timing
- `req` sampled 1 at edge k in IDLE (not full): after edge k `ack`=1, `out_valid`=1, `byte_count`/`last_byte` updated.
- `req` sampled 0 at edge m in ACK_HI: after edge m `ack`=0; `done`=1 after edge m on final byte.
- Minimum 4-phase cycle: 2 clocks per byte.
- Pop: head advances after the edge where `out_valid`&&`out_ready`.
- Reset mid-handshake: `ack` drops immediately; block re-arms only after observing `req`=0 (no duplicate capture).
- `byte_count` never exceeds `PKT_LEN`; pointers wrap modulo `DEPTH`.

## Structure
- Shared package `link_pkg`: state encoding (REL, IDLE, ACK_HI, DONE), byte width constant 8.
- Sub-module `link_sync_fifo` (DEPTH x 8, push/pop/full/empty/count, flush input); handshake FSM and counters in `link_resp_buf`.

## Test plan
- Bytes A1,B2,C3,D4, `PKT_LEN`=4, `out_ready`=1 -> four req/ack cycles, `out_data` sequence A1..D4, `last_byte`=D4, `byte_count`=4, `done`=1 after final `req` fall.
- `out_ready`=0, 6 bytes offered, `DEPTH`=4 -> 4 acks, 5th `req` held with `ack`=0; raise `out_ready` -> 5th acked one clock after first pop frees space.
- FIFO full with pop and `req`=1 same cycle -> no push that cycle, push next cycle; order intact.
- `clr` while `ack`=1 and `req`=1 -> `ack`=0 next cycle, state REL, no recapture until `req` low then high; `byte_count` restarts at 1.
- Assert `rst` low during ACK_HI -> all outputs 0 asynchronously; release with `req`=1 -> no capture until `req` toggles.
- `req`=1 in DONE -> `err`=1 sticky, `byte_count` unchanged, `ack`=0; `clr` clears `err`.

Source files
------------

// File: rtl/link_pkg.sv
// Shared types for the req/ack byte link.
// State encoding and byte width.
package link_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    REL    = 2'd0,
    IDLE   = 2'd1,
    ACK_HI = 2'd2,
    DONE   = 2'd3
  } state_e;

endpackage

// File: rtl/link_resp_buf_if.sv
// Byte link + drain stream bundle.
// master drives req/data/out_ready/clr.
interface link_resp_buf_if;
  import link_pkg::*;

  logic              req;
  logic [BYTE_W-1:0] data;
  logic              ack;
  logic              out_valid;
  logic [BYTE_W-1:0] out_data;
  logic              out_ready;
  logic              clr;
  logic [BYTE_W-1:0] last_byte;
  logic [BYTE_W-1:0] byte_count;
  logic              done;
  logic              err;

  modport master (
    output req, data, out_ready, clr,
    input  ack, out_valid, out_data,
    input  last_byte, byte_count, done, err
  );

  modport slave (
    input  req, data, out_ready, clr,
    output ack, out_valid, out_data,
    output last_byte, byte_count, done, err
  );

endinterface

// File: rtl/link_sync_fifo.sv
// Single-clock FIFO with flush.
// Head reads as zero while empty.
module link_sync_fifo #(
  parameter  int DEPTH = 4,
  parameter  int W     = 8,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          push,
  input  logic [W-1:0]  wdata,
  input  logic          pop,
  output logic [W-1:0]  rdata,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wp_q, rp_q;
  logic [CW-1:0] cnt_q;
  logic          do_push, do_pop;

  assign full    = cnt_q == CW'(DEPTH);
  assign empty   = cnt_q == '0;
  assign count   = cnt_q;
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;
  assign rdata   = empty ? '0 : mem[rp_q];

  // Storage write; contents need no reset
  always_ff @(posedge clk) begin
    if (do_push) mem[wp_q] <= wdata;
  end

  // Pointers and occupancy
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else if (flush) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wp_q <= wp_q + AW'(1);
      if (do_pop)  rp_q <= rp_q + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/link_resp_buf.sv
// Responder end of the 4-phase byte link.
// Captures bytes into a FIFO, tracks packet.
module link_resp_buf
  import link_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int PKT_LEN = 4
) (
  input logic            clk,
  input logic            rst,
  link_resp_buf_if.slave lk
);

  localparam int CW = $clog2(DEPTH) + 1;

  state_e            state_q, state_d;
  logic [BYTE_W-1:0] cnt_q, last_q;
  logic              err_q;
  logic              push, pop, err_set;
  logic              ack, done;
  logic              fifo_full, fifo_empty;
  logic [CW-1:0]     fifo_cnt;
  logic [BYTE_W-1:0] head;
  logic              pkt_end;

  assign pkt_end = cnt_q == BYTE_W'(PKT_LEN);

  // Handshake state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= REL;
    else      state_q <= state_d;
  end

  // Next-state; clr overrides everything
  always_comb begin
    state_d = state_q;
    if (lk.clr) begin
      state_d = lk.req ? REL : IDLE;
    end else begin
      unique case (state_q)
        REL:    if (!lk.req) state_d = IDLE;
        IDLE:   if (lk.req && !fifo_full) state_d = ACK_HI;
        ACK_HI: if (!lk.req) state_d = pkt_end ? DONE : IDLE;
        DONE:   state_d = DONE;
      endcase
    end
  end

  // Decoded outputs and strobes
  always_comb begin
    ack     = 1'b0;
    done    = 1'b0;
    push    = 1'b0;
    err_set = 1'b0;
    unique case (1'b1)
      state_q == ACK_HI: ack = 1'b1;
      state_q == DONE: begin
        done    = 1'b1;
        err_set = lk.req && !lk.clr;
      end
      state_q == IDLE:
        push = lk.req && !fifo_full && !lk.clr;
      default: ;
    endcase
    pop = lk.out_ready && !fifo_empty;
  end

  // Packet counter, last byte, sticky error
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q  <= '0;
      last_q <= '0;
      err_q  <= 1'b0;
    end else if (lk.clr) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      if (push) begin
        cnt_q  <= cnt_q + BYTE_W'(1);
        last_q <= lk.data;
      end
      if (err_set) err_q <= 1'b1;
    end
  end

  link_sync_fifo #(
    .DEPTH (DEPTH),
    .W     (BYTE_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (lk.clr),
    .push  (push),
    .wdata (lk.data),
    .pop   (pop),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_cnt)
  );

  assign lk.ack        = ack;
  assign lk.done       = done;
  assign lk.err        = err_q;
  assign lk.out_valid  = fifo_cnt != '0;
  assign lk.out_data   = head;
  assign lk.last_byte  = last_q;
  assign lk.byte_count = cnt_q;

endmodule
